// File: rtl/spi_baud_generator.sv
// SPI serial-clock generator: derives SCLK from the SPPR/SPR divisor and emits
// one-PCLK sample/shift strobes on each SCLK edge for the shift-register stage.
module spi_baud_generator #(
  parameter int DIV_W = 12
) (
  input  logic             PCLK,
  input  logic             PRESET_n,
  input  logic [1:0]       spi_mode_i,
  input  logic             spiswai_i,
  input  logic [2:0]       sppr_i,
  input  logic [2:0]       spr_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  input  logic             ss_i,
  output logic             sclk_o,
  output logic [DIV_W-1:0] BaudRateDivisor_o,
  output logic             sample_pulse_o,
  output logic             shift_pulse_o
);

  logic [DIV_W-1:0] w_prescale;
  logic [3:0]       w_shamt;
  logic [DIV_W-1:0] w_div;
  logic [DIV_W-1:0] w_half_m1;
  logic             w_active;
  logic             w_is_sample;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_count;
  logic             r_sclk;
  logic             r_cpol;
  logic             r_cpha;
  logic             r_sample;
  logic             r_shift;

  // div = (sppr+1) << (spr+1); the 4-bit shift amount keeps spr=7 from wrapping.
  assign w_prescale = DIV_W'(sppr_i) + DIV_W'(1);
  assign w_shamt    = {1'b0, spr_i} + 4'd1;
  assign w_div      = w_prescale << w_shamt;

  // Half period is taken from the frozen divisor, never the live register fields.
  assign w_half_m1  = (r_div >> 1) - DIV_W'(1);

  assign w_active   = !ss_i && ((spi_mode_i == 2'b00) ||
                                (spi_mode_i == 2'b01 && !spiswai_i));

  // The upcoming edge drives SCLK to ~r_sclk; it samples when that level is ~(cpol^cpha).
  assign w_is_sample = ((~r_sclk) == ~(r_cpol ^ r_cpha));

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      r_div    <= DIV_W'(2);
      r_count  <= '0;
      r_sclk   <= 1'b0;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
    end else if (!w_active) begin
      r_div    <= w_div;
      r_cpol   <= cpol_i;
      r_cpha   <= cpha_i;
      r_count  <= '0;
      r_sclk   <= cpol_i;
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
    end else if (r_count == w_half_m1) begin
      r_count  <= '0;
      r_sclk   <= ~r_sclk;
      r_sample <= w_is_sample;
      r_shift  <= ~w_is_sample;
    end else begin
      r_count  <= r_count + DIV_W'(1);
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
    end
  end

  assign sclk_o            = r_sclk;
  assign BaudRateDivisor_o = r_div;
  assign sample_pulse_o    = r_sample;
  assign shift_pulse_o     = r_shift;

endmodule

// File: tb/tb_spi_baud_generator.sv
// Directed bench for spi_baud_generator: divisor math, SPI modes 0/3, wait/stop
// parking, frozen configuration, mid-transfer abort and asynchronous reset.
module tb_spi_baud_generator;

  logic        PCLK;
  logic        PRESET_n;
  logic [1:0]  spi_mode_i;
  logic        spiswai_i;
  logic [2:0]  sppr_i;
  logic [2:0]  spr_i;
  logic        cpol_i;
  logic        cpha_i;
  logic        ss_i;
  logic        sclk_o;
  logic [11:0] BaudRateDivisor_o;
  logic        sample_pulse_o;
  logic        shift_pulse_o;

  int n_checks = 0;
  int n_fails  = 0;

  spi_baud_generator #(.DIV_W(12)) dut (
    .PCLK              (PCLK),
    .PRESET_n          (PRESET_n),
    .spi_mode_i        (spi_mode_i),
    .spiswai_i         (spiswai_i),
    .sppr_i            (sppr_i),
    .spr_i             (spr_i),
    .cpol_i            (cpol_i),
    .cpha_i            (cpha_i),
    .ss_i              (ss_i),
    .sclk_o            (sclk_o),
    .BaudRateDivisor_o (BaudRateDivisor_o),
    .sample_pulse_o    (sample_pulse_o),
    .shift_pulse_o     (shift_pulse_o)
  );

  // Clock
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one PCLK edge; inputs and outputs are touched 1 ns after it.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic exp_sclk,
                         input logic exp_sample, input logic exp_shift);
    chk({tag, "_sclk"},   sclk_o,         exp_sclk);
    chk({tag, "_sample"}, sample_pulse_o, exp_sample);
    chk({tag, "_shift"},  shift_pulse_o,  exp_shift);
  endtask

  initial begin
    logic exp_sclk;
    PRESET_n   = 1'b0;
    spi_mode_i = 2'b00;
    spiswai_i  = 1'b0;
    sppr_i     = 3'd0;
    spr_i      = 3'd0;
    cpol_i     = 1'b0;
    cpha_i     = 1'b0;
    ss_i       = 1'b1;

    // Reset values
    #12;
    chk("rst_div", BaudRateDivisor_o, 32'd2);
    chk_out("rst", 1'b0, 1'b0, 1'b0);
    @(negedge PCLK);
    PRESET_n = 1'b1;
    #1;

    // Divisor calculation while idle
    sppr_i = 3'd2; spr_i = 3'd1;
    step();
    chk("div_12", BaudRateDivisor_o, 32'd12);
    sppr_i = 3'd7; spr_i = 3'd7;
    step();
    chk("div_2048", BaudRateDivisor_o, 32'd2048);
    cpol_i = 1'b1;
    step();
    chk_out("idle_cpol1", 1'b1, 1'b0, 1'b0);

    // Mode 0, div=2: toggles every cycle, sample on rises, shift on falls
    sppr_i = 3'd0; spr_i = 3'd0; cpol_i = 1'b0; cpha_i = 1'b0;
    step();
    chk("m0_div", BaudRateDivisor_o, 32'd2);
    chk_out("m0_idle", 1'b0, 1'b0, 1'b0);
    ss_i = 1'b0;
    exp_sclk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_sclk = ~exp_sclk;
      chk_out($sformatf("m0_c%0d", i), exp_sclk, exp_sclk, ~exp_sclk);
    end
    ss_i = 1'b1;
    step();
    chk_out("m0_stop", 1'b0, 1'b0, 1'b0);

    // Mode 3, div=8: edge every 4 cycles, leading edge falls and shifts
    sppr_i = 3'd1; spr_i = 3'd1; cpol_i = 1'b1; cpha_i = 1'b1;
    step();
    chk("m3_div", BaudRateDivisor_o, 32'd8);
    chk_out("m3_idle", 1'b1, 1'b0, 1'b0);
    ss_i = 1'b0;
    exp_sclk = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      step();
      if (i % 4 == 0) begin
        exp_sclk = ~exp_sclk;
        chk_out($sformatf("m3_e%0d", i), exp_sclk, exp_sclk, ~exp_sclk);
      end else begin
        chk_out($sformatf("m3_h%0d", i), exp_sclk, 1'b0, 1'b0);
      end
      // spr change mid-transfer must not alter the running period
      if (i == 16) spr_i = 3'd2;
      if (i == 17) chk("m3_frozen_div", BaudRateDivisor_o, 32'd8);
    end
    // Abort mid-half-period: park at cpol with no pulse
    ss_i = 1'b1;
    step();
    chk_out("abort", 1'b1, 1'b0, 1'b0);
    chk("abort_newdiv", BaudRateDivisor_o, 32'd16);
    ss_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 8) chk_out("resume_e8", 1'b0, 1'b0, 1'b1);
      else        chk_out($sformatf("resume_h%0d", i), 1'b1, 1'b0, 1'b0);
    end

    // Wait mode with spiswai: parked, then running once spiswai drops (div=4)
    ss_i = 1'b1; sppr_i = 3'd0; spr_i = 3'd1; cpol_i = 1'b0; cpha_i = 1'b0;
    step();
    chk("wait_div", BaudRateDivisor_o, 32'd4);
    spi_mode_i = 2'b01; spiswai_i = 1'b1; ss_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("wait_park%0d", i), 1'b0, 1'b0, 1'b0);
    end
    spiswai_i = 1'b0;
    step();
    chk_out("wait_run1", 1'b0, 1'b0, 1'b0);
    step();
    chk_out("wait_run2", 1'b1, 1'b1, 1'b0);

    // Stop mode parks at cpol; run mode restarts counting from zero
    spi_mode_i = 2'b10;
    step();
    chk_out("stop_park", 1'b0, 1'b0, 1'b0);
    spi_mode_i = 2'b00;
    step();
    chk_out("run_h1", 1'b0, 1'b0, 1'b0);
    step();
    chk_out("run_e2", 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-transfer, away from any clock edge
    #2;
    PRESET_n = 1'b0;
    #1;
    chk("arst_div", BaudRateDivisor_o, 32'd2);
    chk_out("arst", 1'b0, 1'b0, 1'b0);
    #10;
    PRESET_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
